gpu_command_decoder: RTL and testbench

//   Upstream stage of the GPU fill/blit engine. Consumes a byte stream from the host link (UART RX FIFO).

---
 rtl/gpu_command_decoder.sv | 192 +++++++++++++++++++
 tb/tb_gpu_command_decoder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_command_decoder.sv
// gpu_command_decoder
// Assembles 7-byte fill/blit commands from the host byte stream, range-checks
// the rectangle and hands it to the fill/blit engine with a one-cycle strobe.
// Malformed, unknown or stalled commands are dropped with a cmd_error pulse.
module gpu_command_decoder #(
    parameter int unsigned SCREEN_W       = 320,
    parameter int unsigned SCREEN_H       = 240,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       gpu_busy,
    output logic [8:0] X1,
    output logic [7:0] Y1,
    output logic [8:0] X2,
    output logic [7:0] Y2,
    output logic       fill_value,
    output logic       start_fill,
    output logic       start_blt,
    output logic       cmd_error,
    output logic       dec_busy
);

    localparam int unsigned   TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit            TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [9:0]    W_LIM    = 10'(SCREEN_W);
    localparam logic [8:0]    H_LIM    = 9'(SCREEN_H);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAYLOAD,
        S_CHECK,
        S_ISSUE,
        S_GUARD
    } state_t;

    state_t        state;
    state_t        next_state;

    logic [47:0]   pl_sr;      // payload bytes, first byte ends up in [47:40]
    logic [2:0]    pl_cnt;
    logic          op_blt;
    logic          op_val;
    logic [TW-1:0] tmo_cnt;

    logic          xfer;
    logic          load_op;
    logic          store_byte;
    logic          issue;
    logic          err_set;
    logic          tmo_hit;

    logic [8:0]    cx1;
    logic [8:0]    cx2;
    logic [7:0]    cy1;
    logic [7:0]    cy2;
    logic          cmd_ok;

    assign xfer     = in_valid & in_ready;
    assign dec_busy = (state != S_IDLE);
    assign tmo_hit  = TMO_EN && (tmo_cnt == TMO_LAST);

    // Unpack the assembled payload and range-check the rectangle
    always_comb begin
        cx1    = {pl_sr[40], pl_sr[39:32]};
        cy1    = pl_sr[31:24];
        cx2    = {pl_sr[16], pl_sr[15:8]};
        cy2    = pl_sr[7:0];
        cmd_ok = (pl_sr[47:41] == 7'd0) && (pl_sr[23:17] == 7'd0)
              && (cx1 <= cx2) && (cy1 <= cy2)
              && ({1'b0, cx2} < W_LIM) && ({1'b0, cy2} < H_LIM);
    end

    // Next-state and control decode
    always_comb begin
        next_state = state;
        load_op    = 1'b0;
        store_byte = 1'b0;
        issue      = 1'b0;
        err_set    = 1'b0;
        case (state)
            S_IDLE: begin
                if (xfer) begin
                    case (in_data[7:4])
                        4'h0: ;
                        4'h1, 4'h2: begin
                            load_op    = 1'b1;
                            next_state = S_PAYLOAD;
                        end
                        default: err_set = 1'b1;
                    endcase
                end
            end
            S_PAYLOAD: begin
                if (xfer) begin
                    store_byte = 1'b1;
                    if (pl_cnt == 3'd5) begin
                        next_state = S_CHECK;
                    end
                end else if (tmo_hit) begin
                    err_set    = 1'b1;
                    next_state = S_IDLE;
                end
            end
            S_CHECK: begin
                if (cmd_ok) begin
                    next_state = S_ISSUE;
                end else begin
                    err_set    = 1'b1;
                    next_state = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (!gpu_busy) begin
                    issue      = 1'b1;
                    next_state = S_GUARD;
                end
            end
            S_GUARD: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Opcode latch, payload shift register and inter-byte timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pl_sr   <= '0;
            pl_cnt  <= '0;
            op_blt  <= 1'b0;
            op_val  <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            if (load_op) begin
                op_blt <= (in_data[7:4] == 4'h2);
                op_val <= in_data[0];
                pl_cnt <= '0;
            end
            if (store_byte) begin
                pl_sr  <= {pl_sr[39:0], in_data};
                pl_cnt <= pl_cnt + 3'd1;
            end
            if (TMO_EN && (state == S_PAYLOAD) && !xfer && !tmo_hit) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    // Registered handshake, strobes and held rectangle outputs.
    // in_ready is registered from next_state so it stays low through reset
    // and rises on the first edge after release; otherwise it tracks state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready   <= 1'b0;
            start_fill <= 1'b0;
            start_blt  <= 1'b0;
            cmd_error  <= 1'b0;
            X1         <= '0;
            Y1         <= '0;
            X2         <= '0;
            Y2         <= '0;
            fill_value <= 1'b0;
        end else begin
            in_ready   <= (next_state == S_IDLE) || (next_state == S_PAYLOAD);
            start_fill <= issue & ~op_blt;
            start_blt  <= issue & op_blt;
            cmd_error  <= err_set;
            if (issue) begin
                X1         <= cx1;
                Y1         <= cy1;
                X2         <= cx2;
                Y2         <= cy2;
                fill_value <= op_val;
            end
        end
    end

endmodule

// File: tb/tb_gpu_command_decoder.sv
// Testbench for gpu_command_decoder: directed scenarios plus random commands,
// checked against a byte-level command model and a simple engine model.
`timescale 1ns/1ps
module tb_gpu_command_decoder;

    localparam int K_NONE = 0;
    localparam int K_FILL = 1;
    localparam int K_BLT  = 2;
    localparam int K_ERR  = 3;

    typedef struct {
        int kind;
        int x1;
        int y1;
        int x2;
        int y2;
        int fv;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       gpu_busy;
    logic       busy_force = 1'b0;
    logic       eng_busy = 1'b0;
    logic [8:0] X1;
    logic [7:0] Y1;
    logic [8:0] X2;
    logic [7:0] Y2;
    logic       fill_value;
    logic       start_fill;
    logic       start_blt;
    logic       cmd_error;
    logic       dec_busy;

    int  checks = 0;
    int  errors = 0;
    ev_t evq[$];
    ev_t last = '{default: 0};
    ev_t mon_e;
    int  eng_cnt = 0;
    int  eng_dur_fixed = 0;
    logic prev_busy = 1'b0;

    assign gpu_busy = busy_force | eng_busy;

    always #5 clk = ~clk;

    gpu_command_decoder #(
        .SCREEN_W      (320),
        .SCREEN_H      (240),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .gpu_busy  (gpu_busy),
        .X1        (X1),
        .Y1        (Y1),
        .X2        (X2),
        .Y2        (Y2),
        .fill_value(fill_value),
        .start_fill(start_fill),
        .start_blt (start_blt),
        .cmd_error (cmd_error),
        .dec_busy  (dec_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Event monitor and engine model: record strobes/errors, keep engine busy after each strobe
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            evq.delete();
            eng_cnt = 0;
        end else begin
            if (start_fill || start_blt || cmd_error) begin
                check("one_event", 32'($countones({start_fill, start_blt, cmd_error})), 32'd1);
                if (start_fill || start_blt) check("strobe_while_busy", 32'(prev_busy), 32'd0);
                mon_e.kind = start_fill ? K_FILL : (start_blt ? K_BLT : K_ERR);
                mon_e.x1   = int'(X1);
                mon_e.y1   = int'(Y1);
                mon_e.x2   = int'(X2);
                mon_e.y2   = int'(Y2);
                mon_e.fv   = int'(fill_value);
                evq.push_back(mon_e);
            end
            if (start_fill || start_blt)
                eng_cnt = (eng_dur_fixed > 0) ? eng_dur_fixed : int'($urandom_range(1, 12));
            else if (eng_cnt > 0)
                eng_cnt--;
        end
        eng_busy  = (eng_cnt > 0);
        prev_busy = busy_force | eng_busy;
    end

    // Reference: what a 7-byte command must produce, from the command format rules
    function automatic ev_t model_cmd(input int b[7]);
        ev_t e;
        int  op;
        e  = '{default: 0};
        op = b[0] / 16;
        if (op == 0) begin
            e.kind = K_NONE;
        end else if (op > 2) begin
            e.kind = K_ERR;
        end else begin
            e.x1 = (b[1] % 2) * 256 + b[2];
            e.y1 = b[3];
            e.x2 = (b[4] % 2) * 256 + b[5];
            e.y2 = b[6];
            e.fv = b[0] % 2;
            if (b[1] < 2 && b[4] < 2 && e.x1 <= e.x2 && e.y1 <= e.y2 && e.x2 < 320 && e.y2 < 240)
                e.kind = op;
            else
                e = '{kind: K_ERR, default: 0};
        end
        return e;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("byte_accepted", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_cmd(input int c[7]);
        int n;
        n = (c[0] / 16 == 1 || c[0] / 16 == 2) ? 7 : 1;
        for (int i = 0; i < n; i++) begin
            send_byte(8'(c[i]));
            if (i < n - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic expect_ev(input ev_t exp, input int exp_lat);
        ev_t got;
        int  lat;
        if (exp.kind == K_NONE) begin
            repeat (4) @(negedge clk);
            #2;
            check("nop_no_event", 32'(evq.size()), 32'd0);
            return;
        end
        #2;
        lat = 0;
        while (evq.size() == 0 && lat < 400) begin
            @(negedge clk);
            #2;
            lat++;
        end
        check("event_seen", 32'(evq.size() != 0), 32'd1);
        if (evq.size() == 0) return;
        got = evq.pop_front();
        check("event_kind", 32'(got.kind), 32'(exp.kind));
        if (exp_lat >= 0) check("event_latency", 32'(lat), 32'(exp_lat));
        if (exp.kind != K_ERR) begin
            check("strobe_x1", 32'(got.x1), 32'(exp.x1));
            check("strobe_y1", 32'(got.y1), 32'(exp.y1));
            check("strobe_x2", 32'(got.x2), 32'(exp.x2));
            check("strobe_y2", 32'(got.y2), 32'(exp.y2));
            check("strobe_fv", 32'(got.fv), 32'(exp.fv));
            last = exp;
        end
    endtask

    task automatic settle_and_hold();
        int n = 0;
        while ((dec_busy || gpu_busy) && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("settle_idle", 32'({dec_busy, gpu_busy}), 32'd0);
        check("hold_x1", 32'(X1), 32'(last.x1));
        check("hold_y1", 32'(Y1), 32'(last.y1));
        check("hold_x2", 32'(X2), 32'(last.x2));
        check("hold_y2", 32'(Y2), 32'(last.y2));
        check("hold_fv", 32'(fill_value), 32'(last.fv));
        check("no_extra_event", 32'(evq.size()), 32'd0);
    endtask

    task automatic run_cmd(input int c[7], input int exp_lat);
        send_cmd(c);
        expect_ev(model_cmd(c), exp_lat);
        settle_and_hold();
    endtask

    task automatic cmd7(input int a0, input int a1, input int a2, input int a3,
                        input int a4, input int a5, input int a6, input int lat);
        int c[7];
        c = '{a0, a1, a2, a3, a4, a5, a6};
        run_cmd(c, lat);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_xy"}, 32'({X1, Y1, X2}), 32'd0);
        check({tag, "_ctl"}, 32'({Y2, fill_value, start_fill, start_blt, cmd_error, in_ready, dec_busy}), 32'd0);
    endtask

    initial begin
        int  c[7];
        int  ca[7];
        int  cb[7];
        ev_t e;
        int  x1, x2, y1, y2, r;

        // Reset behaviour and in_ready release
        repeat (2) @(negedge clk);
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check("in_ready_in_release_cycle", 32'(in_ready), 32'd0);
        @(negedge clk);
        #2;
        check("in_ready_after_release", 32'(in_ready), 32'd1);

        // Basic fill, issue latency two cycles after last byte
        cmd7('h10, 'h00, 'h0A, 'h14, 'h00, 'h1D, 'h1E, 2);
        // Max corner blit accepted, then X2 = 320 rejected
        cmd7('h21, 'h01, 'h3F, 'hEF, 'h01, 'h3F, 'hEF, 2);
        cmd7('h21, 'h01, 'h3F, 'hEF, 'h01, 'h40, 'hEF, 1);
        // X1 > X2 rejected, bad opcode rejected, NOP silent
        cmd7('h11, 'h00, 'h20, 'h00, 'h00, 'h10, 'h00, 1);
        cmd7('h5F, 0, 0, 0, 0, 0, 0, 0);
        check("idle_after_bad_op", 32'(dec_busy), 32'd0);
        cmd7('h0F, 0, 0, 0, 0, 0, 0, -1);
        // hi[7:1] nonzero rejected
        cmd7('h11, 'h02, 'h01, 'h01, 'h00, 'h05, 'h05, 1);

        // Engine busy holds the issue; strobe the cycle after busy falls
        @(negedge clk);
        busy_force = 1'b1;
        c = '{'h11, 'h00, 'h03, 'h04, 'h00, 'h09, 'h0A};
        send_cmd(c);
        repeat (50) @(negedge clk);
        #2;
        check("busy_no_strobe", 32'(evq.size()), 32'd0);
        check("busy_in_ready_low", 32'(in_ready), 32'd0);
        check("busy_dec_busy", 32'(dec_busy), 32'd1);
        @(negedge clk);
        busy_force = 1'b0;
        expect_ev(model_cmd(c), 1);
        settle_and_hold();

        // Back-to-back fills: second strobe only after engine busy clears
        eng_dur_fixed = 15;
        ca = '{'h11, 'h00, 'h01, 'h02, 'h00, 'h21, 'h22};
        cb = '{'h10, 'h00, 'h05, 'h06, 'h00, 'h07, 'h08};
        send_cmd(ca);
        send_cmd(cb);
        expect_ev(model_cmd(ca), -1);
        expect_ev(model_cmd(cb), -1);
        settle_and_hold();
        eng_dur_fixed = 0;

        // Inter-byte timeout after 16 idle cycles, then a clean command
        send_byte(8'h11);
        send_byte(8'h00);
        send_byte(8'h05);
        e = '{kind: K_ERR, default: 0};
        expect_ev(e, 16);
        settle_and_hold();
        cmd7('h20, 'h00, 'h30, 'h31, 'h00, 'h40, 'h41, 2);

        // Reset mid-command clears outputs, partial command discarded
        send_byte(8'h13);
        send_byte(8'h00);
        send_byte(8'h05);
        send_byte(8'h07);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check_all_zero("midcmd_reset");
        last = '{default: 0};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        check("in_ready_after_rerelease", 32'(in_ready), 32'd1);
        cmd7('h13, 'h00, 'h01, 'h02, 'h00, 'h03, 'h04, 2);

        // Randomized commands against the model
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            x1 = int'($urandom_range(0, 330));
            x2 = int'($urandom_range(0, 330));
            y1 = int'($urandom_range(0, 250));
            y2 = int'($urandom_range(0, 250));
            if (r == 0)      c[0] = int'($urandom_range(0, 15));
            else if (r == 1) c[0] = int'($urandom_range(3, 15)) * 16 + int'($urandom_range(0, 15));
            else             c[0] = int'($urandom_range(1, 2)) * 16 + int'($urandom_range(0, 15));
            c[1] = x1 / 256 + (($urandom_range(0, 9) == 0) ? 2 * int'($urandom_range(1, 127)) : 0);
            c[2] = x1 % 256;
            c[3] = y1;
            c[4] = x2 / 256 + (($urandom_range(0, 9) == 0) ? 2 * int'($urandom_range(1, 127)) : 0);
            c[5] = x2 % 256;
            c[6] = y2;
            run_cmd(c, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
